// File: rtl/alu_req_issuer.sv
// rtl/alu_req_issuer.sv - request FIFO that issues paced single beats to the ALU input bus
// Define ALU_CMD_FILTER_EN to discard requests whose MODE/CMD pair the ALU does not implement.
module alu_req_issuer #(
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 4,
  parameter int DEPTH   = 4,
  parameter int OP_LAT  = 1,
  parameter int MUL_LAT = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_mode,
  input  logic [CWIDTH-1:0]        req_cmd,
  input  logic                     req_cin,
  input  logic [WIDTH-1:0]         req_opa,
  input  logic [WIDTH-1:0]         req_opb,
  output logic [1:0]               INP_VALID,
  output logic                     MODE,
  output logic                     CIN,
  output logic                     CE,
  output logic [WIDTH-1:0]         OPA,
  output logic [WIDTH-1:0]         OPB,
  output logic [CWIDTH-1:0]        CMD,
  output logic                     busy,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int EW   = 2 + CWIDTH + 2 * WIDTH;
  localparam int MAXL = (MUL_LAT > OP_LAT) ? MUL_LAT : OP_LAT;
  localparam int GW   = $clog2(MAXL + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state;
  logic [GW-1:0]       gap;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [EW-1:0]       mem [DEPTH];

  logic                h_mode;
  logic [CWIDTH-1:0]   h_cmd;
  logic                h_cin;
  logic [WIDTH-1:0]    h_opa;
  logic [WIDTH-1:0]    h_opb;
  logic                push;
  logic                pop;
  logic                legal;
  logic                is_mul;
  logic                slot_open;

  assign {h_mode, h_cmd, h_cin, h_opa, h_opb} = mem[rd_ptr];

  assign req_ready = !RST && (fifo_count != FULL);
  assign push      = req_valid && req_ready;
  // A pop may happen in IDLE or on the final WAIT cycle, so beats stay back-to-back at the minimum gap.
  assign slot_open = (state == IDLE) || ((state == WAIT) && (gap == GW'(1)));
  assign pop       = !RST && (fifo_count != '0) && slot_open;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign is_mul    = MODE && ((CMD == CWIDTH'(9)) || (CMD == CWIDTH'(10)));

`ifdef ALU_CMD_FILTER_EN
  assign legal = h_mode ? (int'(h_cmd) <= 10) : (int'(h_cmd) <= 13);
`else
  assign legal = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {req_mode, req_cmd, req_cin, req_opa, req_opb};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      gap       <= '0;
      INP_VALID <= 2'b00;
      MODE      <= 1'b0;
      CIN       <= 1'b0;
      CE        <= 1'b0;
      OPA       <= '0;
      OPB       <= '0;
      CMD       <= '0;
      drop      <= 1'b0;
    end else begin
      CE   <= 1'b1;
      drop <= 1'b0;
      case (state)
        ISSUE: begin
          INP_VALID <= 2'b00;
          gap       <= is_mul ? GW'(MUL_LAT) : GW'(OP_LAT);
          state     <= WAIT;
        end
        default: begin
          if (slot_open) begin
            state <= IDLE;
            if (pop) begin
              if (legal) begin
                INP_VALID <= 2'b11;
                MODE      <= h_mode;
                CIN       <= h_cin;
                OPA       <= h_opa;
                OPB       <= h_opb;
                CMD       <= h_cmd;
                state     <= ISSUE;
              end else begin
                drop <= 1'b1;
              end
            end
          end else begin
            gap <= gap - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_issuer.sv
// tb/tb_alu_req_issuer.sv - directed self-checking bench for alu_req_issuer
module tb_alu_req_issuer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_mode = 1'b0;
  logic [3:0] req_cmd = '0;
  logic       req_cin = 1'b0;
  logic [7:0] req_opa = '0;
  logic [7:0] req_opb = '0;
  logic [1:0] INP_VALID;
  logic       MODE, CIN, CE, busy, drop;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic [2:0] fifo_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int bad_iv = 0;
  int drops = 0;

  typedef struct {
    int         c;
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] opa;
    logic [7:0] opb;
  } beat_t;
  beat_t beats[$];

  alu_req_issuer dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_cin(req_cin), .req_opa(req_opa), .req_opb(req_opb),
    .INP_VALID(INP_VALID), .MODE(MODE), .CIN(CIN), .CE(CE),
    .OPA(OPA), .OPB(OPB), .CMD(CMD),
    .busy(busy), .drop(drop), .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (INP_VALID == 2'b11) beats.push_back('{cyc, MODE, CMD, OPA, OPB});
    else if (INP_VALID != 2'b00) bad_iv = bad_iv + 1;
    if (drop) drops = drops + 1;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_req(input logic m, input logic [3:0] c, input logic ci,
                          input logic [7:0] a, input logic [7:0] b);
    req_valid = 1'b1; req_mode = m; req_cmd = c; req_cin = ci; req_opa = a; req_opb = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; req_valid = 1'b0;
    step(); step();
    total_cnt++; if (INP_VALID !== 2'b00) $display("FAIL rst_inp_valid: got %b exp 00", INP_VALID); else pass_cnt++;
    total_cnt++; if (CE !== 1'b0) $display("FAIL rst_ce: got %b exp 0", CE); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", req_ready); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL rst_count: got %0d exp 0", fifo_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if ({MODE, CIN, OPA, OPB, CMD, drop} !== 23'd0)
      $display("FAIL rst_bus: got %h exp 0", {MODE, CIN, OPA, OPB, CMD, drop}); else pass_cnt++;
    RST = 1'b0;
    step();
    total_cnt++; if (CE !== 1'b1) $display("FAIL post_rst_ce: got %b exp 1", CE); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready: got %b exp 1", req_ready); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL post_rst_count: got %0d exp 0", fifo_count); else pass_cnt++;
  endtask

  task automatic test_single_add();
    beats.delete();
    push_req(1'b1, 4'd0, 1'b0, 8'h05, 8'h03);
    total_cnt++; if (INP_VALID !== 2'b00) $display("FAIL add_n1_valid: got %b exp 00", INP_VALID); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL add_n1_busy: got %b exp 1", busy); else pass_cnt++;
    step();
    total_cnt++; if (INP_VALID !== 2'b11) $display("FAIL add_n2_valid: got %b exp 11", INP_VALID); else pass_cnt++;
    total_cnt++; if ({MODE, CMD, OPA, OPB, CIN} !== {1'b1, 4'd0, 8'h05, 8'h03, 1'b0})
      $display("FAIL add_n2_fields: got %h exp %h", {MODE, CMD, OPA, OPB, CIN}, {1'b1, 4'd0, 8'h05, 8'h03, 1'b0}); else pass_cnt++;
    step();
    total_cnt++; if (INP_VALID !== 2'b00) $display("FAIL add_n3_valid: got %b exp 00", INP_VALID); else pass_cnt++;
    total_cnt++; if (OPA !== 8'h05) $display("FAIL add_n3_hold: got %h exp 05", OPA); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL add_n3_busy: got %b exp 1", busy); else pass_cnt++;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL add_n4_busy: got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (beats.size() != 1) $display("FAIL add_beats: got %0d exp 1", beats.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    beats.delete();
    push_req(1'b0, 4'd0, 1'b0, 8'hAA, 8'h0F);
    push_req(1'b0, 4'd2, 1'b0, 8'h11, 8'h22);
    repeat (6) step();
    total_cnt++; if (beats.size() != 2) $display("FAIL b2b_beats: got %0d exp 2", beats.size()); else pass_cnt++;
    if (beats.size() >= 2) begin
      total_cnt++; if (beats[1].c - beats[0].c != 2) $display("FAIL b2b_gap: got %0d exp 2", beats[1].c - beats[0].c); else pass_cnt++;
      total_cnt++; if ({beats[0].cmd, beats[0].opa} !== {4'd0, 8'hAA})
        $display("FAIL b2b_first: got %h exp 0aa", {beats[0].cmd, beats[0].opa}); else pass_cnt++;
      total_cnt++; if ({beats[1].cmd, beats[1].opa, beats[1].opb} !== {4'd2, 8'h11, 8'h22})
        $display("FAIL b2b_second: got %h exp 21122", {beats[1].cmd, beats[1].opa, beats[1].opb}); else pass_cnt++;
    end
  endtask

  task automatic test_mul_pacing();
    beats.delete();
    push_req(1'b1, 4'd9, 1'b0, 8'h07, 8'h06);
    push_req(1'b1, 4'd0, 1'b1, 8'h01, 8'h02);
    repeat (10) step();
    total_cnt++; if (beats.size() != 2) $display("FAIL mul_beats: got %0d exp 2", beats.size()); else pass_cnt++;
    if (beats.size() >= 2) begin
      total_cnt++; if (beats[1].c - beats[0].c != 4) $display("FAIL mul_gap: got %0d exp 4", beats[1].c - beats[0].c); else pass_cnt++;
      total_cnt++; if ({beats[0].mode, beats[0].cmd} !== {1'b1, 4'd9})
        $display("FAIL mul_first: got %h exp 19", {beats[0].mode, beats[0].cmd}); else pass_cnt++;
    end
  endtask

  task automatic test_full_fifo();
    int sent = 0;
    int stalls = 0;
    int guard = 0;
    bit saw_full = 0;
    bit acc;
    beats.delete();
    push_req(1'b1, 4'd9, 1'b0, 8'h10, 8'h00);
    while (sent < 6 && guard < 60) begin
      req_valid = 1'b1; req_mode = 1'b0; req_cmd = 4'd1; req_cin = 1'b0;
      req_opa = 8'(8'h20 + sent); req_opb = 8'(sent);
      if (fifo_count == 3'd4) begin
        saw_full = 1;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL full_ready: got %b exp 0", req_ready); else pass_cnt++;
      end
      acc = req_ready;
      if (!acc) stalls++;
      step();
      if (acc) sent++;
      guard++;
    end
    req_valid = 1'b0;
    guard = 0;
    while (busy && guard < 200) begin step(); guard++; end
    total_cnt++; if (busy !== 1'b0) $display("FAIL full_drain: got busy=%b exp 0", busy); else pass_cnt++;
    total_cnt++; if (sent != 6) $display("FAIL full_sent: got %0d exp 6", sent); else pass_cnt++;
    total_cnt++; if (!saw_full || stalls == 0) $display("FAIL full_stall: got full=%0d stalls=%0d exp full=1 stalls>0", saw_full, stalls); else pass_cnt++;
    total_cnt++; if (beats.size() != 7) $display("FAIL full_beats: got %0d exp 7", beats.size()); else pass_cnt++;
    if (beats.size() == 7) begin
      total_cnt++; if (beats[1].c - beats[0].c != 4) $display("FAIL full_mul_gap: got %0d exp 4", beats[1].c - beats[0].c); else pass_cnt++;
      for (int i = 0; i < 7; i++) begin
        logic [7:0] exp_opa;
        exp_opa = (i == 0) ? 8'h10 : 8'(8'h20 + i - 1);
        total_cnt++; if (beats[i].opa !== exp_opa) $display("FAIL full_order_%0d: got %h exp %h", i, beats[i].opa, exp_opa); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    push_req(1'b1, 4'd10, 1'b1, 8'h33, 8'h44);
    push_req(1'b0, 4'd3, 1'b0, 8'h55, 8'h66);
    step();
    total_cnt++; if (fifo_count !== 3'd1) $display("FAIL rmw_pre_count: got %0d exp 1", fifo_count); else pass_cnt++;
    RST = 1'b1;
    step();
    total_cnt++; if (INP_VALID !== 2'b00) $display("FAIL rmw_valid: got %b exp 00", INP_VALID); else pass_cnt++;
    total_cnt++; if ({MODE, CIN, OPA, OPB, CMD, CE} !== 23'd0)
      $display("FAIL rmw_bus: got %h exp 0", {MODE, CIN, OPA, OPB, CMD, CE}); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL rmw_count: got %0d exp 0", fifo_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmw_busy: got %b exp 0", busy); else pass_cnt++;
    RST = 1'b0;
    beats.delete();
    repeat (6) step();
    total_cnt++; if (beats.size() != 0) $display("FAIL rmw_lost: got %0d beats exp 0", beats.size()); else pass_cnt++;
  endtask

  task automatic test_filter();
    beats.delete();
    drops = 0;
    push_req(1'b1, 4'd11, 1'b0, 8'h5A, 8'hA5);
    repeat (5) step();
`ifdef ALU_CMD_FILTER_EN
    total_cnt++; if (drops != 1) $display("FAIL filt_drop: got %0d exp 1", drops); else pass_cnt++;
    total_cnt++; if (beats.size() != 0) $display("FAIL filt_beats: got %0d exp 0", beats.size()); else pass_cnt++;
`else
    total_cnt++; if (drops != 0) $display("FAIL filt_drop: got %0d exp 0", drops); else pass_cnt++;
    total_cnt++; if (beats.size() != 1) $display("FAIL filt_beats: got %0d exp 1", beats.size()); else pass_cnt++;
`endif
    total_cnt++; if (busy !== 1'b0) $display("FAIL filt_busy: got %b exp 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_mul_pacing();
    test_full_fifo();
    test_reset_mid_wait();
    test_filter();
    total_cnt++; if (bad_iv != 0) $display("FAIL inp_valid_encoding: got %0d bad beats exp 0", bad_iv); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
